demux_stream_1xn: RTL
=====================

# demux_stream_1xn

Registered, parametrised 1-to-N stream demultiplexer with valid/ready flow control, broadcast mode and out-of-range select detection. It generalises the fixed 1x16 demux trees in the same codebase to arbitrary channel count and data width. Every output channel gets a one-entry holding register, so slow consumers back-pressure only the traffic aimed at them. The block sits between a single producer and N independent consumers.

## Interface
- N_CH, 16: number of output channels, legal range 2..16 (need not be a power of 2).
- DW, 8: data width in bits.
- SEL_W, 4: select width. Must satisfy 2**SEL_W >= N_CH.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  producer holds a word.
- in_ready  out  1  block accepts the word this cycle.
- in_sel  in  SEL_W  destination channel.
- in_bcast  in  1  when 1, copy the word to all channels and ignore in_sel.
- in_data  in  DW  payload.
- out_valid  out  N_CH  per-channel valid.
- out_ready  in  N_CH  per-channel consumer ready.
- out_data  out  N_CH*DW  channel k occupies bits [k*DW +: DW].
- err_sel  out  1  one-cycle pulse when a word with out-of-range in_sel is accepted.
- drop_cnt  out  8  saturating count of dropped words.

## Operation
- Input handshake: the block accepts a word on any cycle where in_valid and in_ready are both 1.
- Channel k is "free" when !out_valid[k] or out_ready[k] (empty, or draining this cycle).
- in_ready rules:
  - Unicast, in_sel < N_CH: in_ready = free[in_sel].
  - Broadcast: in_ready = AND of free over all N_CH channels. The copy is all-or-nothing.
  - Out-of-range in_sel (in_sel >= N_CH, unicast only): in_ready = 1. The word is discarded, err_sel pulses, and drop_cnt increments, saturating at 255.
- Accepted unicast word:
  - Loads out_data[sel] and sets out_valid[sel].
  - Other channels are untouched.
- Accepted broadcast word loads all channels and sets all out_valid bits.
- Channel k output handshake: out_valid[k] && out_ready[k] clears out_valid[k]. If a load to k happens in the same cycle, out_valid[k] stays 1 and the new data replaces the old.
- out_valid[k] never drops without out_ready[k], and out_data[k] stays stable while out_valid[k] is 1.
- out_data holds its last value after the word is drained.
- in_ready depends combinationally on in_valid-independent state plus in_sel, in_bcast and out_ready. There is no combinational path from in_valid to in_ready.
- Mode encoding: in_bcast=0 is unicast, in_bcast=1 is broadcast. Broadcast never raises err_sel.

## Timing
- Latency: a word accepted at edge t is visible on out_valid/out_data right after edge t.
- Throughput: one word per cycle per channel when the consumer holds out_ready=1.
- Reset, with rst_n low at a rising edge:
  - out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0.
  - Any words held in the channel registers are lost.
  - in_ready may be asserted during reset, but nothing is captured while rst_n = 0.
- err_sel is registered: it is high for exactly the cycle after the dropping edge.
- drop_cnt updates on the same edge as err_sel.
- drop_cnt at 255 stays at 255 and err_sel still pulses.
- Back-to-back unicast words to the same channel with out_ready=1 give continuous out_valid=1 with new data every cycle.

## Structure
- Shared package/header `demux_pkg`:
  - mode constants `DEMUX_UNICAST` and `DEMUX_BCAST`.
  - drop-counter width constant `DEMUX_DROP_W = 8`.
  - the `clog2` helper used to check SEL_W.
- Sub-module `demux_chan_reg`: one-entry holding register.
  - Ports: load, din, ready, valid, dout.
  - Instantiated N_CH times in a generate loop.
- Top level holds only the free-vector computation, the in_ready mux, the load decode, and the drop counter/err_sel logic.
- Elaboration-time check: fail if 2**SEL_W < N_CH or N_CH is outside 2..16.

## Test plan
- Reset and single unicast:
  - Stimulus: after reset, unicast in_sel=5, data 8'hA5, out_ready[5]=0.
  - Response: out_valid=16'h0020 one cycle later and out_data[5]=A5.
  - A second word to channel 5 sees in_ready=0.
  - A word to channel 3 is accepted.
- Back-pressure release:
  - Stimulus: channel 5 full, out_ready[5] raised while a new word to channel 5 is offered.
  - Response: same-cycle accept, out_valid[5] stays 1, and the next data is visible after the edge.
- Broadcast blocking:
  - Stimulus: channel 2 full with out_ready[2]=0, broadcast 8'h3C.
  - Response: in_ready=0 and no channel loads.
  - Then release out_ready[2]: all 16 channels show 3C after the edge.
- Out-of-range select:
  - Stimulus: N_CH=10, SEL_W=4, in_sel=12.
  - Response: accepted, err_sel pulses one cycle, drop_cnt=1, out_valid unchanged.
  - After 300 such words, drop_cnt=255.
- Mid-operation reset:
  - Stimulus: several channels full, rst_n=0 for one edge.
  - Response: out_valid=0, out_data=0, drop_cnt=0 after the edge.
- Randomised unicast/broadcast traffic against a scoreboard (N_CH=4, DW=16):
  - no lost or duplicated words;
  - per-channel order preserved;
  - out_data stable while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared mode constants, drop-counter width and clog2 helper for the stream demux
package demux_pkg;
  localparam logic DEMUX_UNICAST = 1'b0;
  localparam logic DEMUX_BCAST = 1'b1;
  localparam int DEMUX_DROP_W = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/demux_stream_1xn_if.sv
// demux_stream_1xn_if: producer-side and consumer-side stream signals of the 1-to-N demux
// Ports: in_valid/in_ready/in_sel/in_bcast/in_data (producer), out_valid/out_ready/out_data
// (N consumers, channel k at out_data[k*DW +: DW]), err_sel pulse and drop_cnt status.
// master = producer/consumer side, slave = demux side.
interface demux_stream_1xn_if #(
  parameter int N_CH = 16,
  parameter int DW = 8,
  parameter int SEL_W = 4
);
  import demux_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [SEL_W-1:0] in_sel;
  logic in_bcast;
  logic [DW-1:0] in_data;
  logic [N_CH-1:0] out_valid;
  logic [N_CH-1:0] out_ready;
  logic [N_CH*DW-1:0] out_data;
  logic err_sel;
  logic [DEMUX_DROP_W-1:0] drop_cnt;
  modport master (
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input in_ready, out_valid, out_data, err_sel, drop_cnt
  );
  modport slave (
    input in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data, err_sel, drop_cnt
  );
endinterface

// File: rtl/demux_chan_reg.sv
// demux_chan_reg: one-entry holding register for a single output channel
// Ports: clk, rst_n (sync active-low), load/din (write), ready (consumer), valid/dout (held word).
module demux_chan_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] dout
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      // a load in the draining cycle keeps valid high with fresh data
      valid <= load | (valid & ~ready);
      if (load) dout <= din;
    end
  end
endmodule

// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: registered 1-to-N valid/ready demux with broadcast and out-of-range drop
// Ports: clk, rst_n (sync active-low), bus (demux_stream_1xn_if.slave) carrying the producer
// stream, the N consumer channels, err_sel pulse and saturating drop_cnt.
module demux_stream_1xn
  import demux_pkg::*;
#(
  parameter int N_CH = 16,
  parameter int DW = 8,
  parameter int SEL_W = 4
) (
  input logic clk,
  input logic rst_n,
  demux_stream_1xn_if.slave bus
);
  localparam int NP = 1 << SEL_W;
  localparam logic [SEL_W:0] N_CH_V = (SEL_W + 1)'(N_CH);
  if (N_CH < 2 || N_CH > 16 || SEL_W < clog2(N_CH)) begin : g_bad_cfg
    $error("demux_stream_1xn: illegal N_CH/SEL_W combination");
  end
  logic [N_CH-1:0] free;
  logic [NP-1:0] free_pad;
  logic [N_CH-1:0] load;
  logic bcast, sel_ok, acc, drop;
  logic valid_a [N_CH];
  logic [DW-1:0] dout_a [N_CH];
  assign bcast = bus.in_bcast == DEMUX_BCAST;
  assign free = ~bus.out_valid | bus.out_ready;
  // padded so out-of-range selects index a defined bit; that branch is masked anyway
  assign free_pad = NP'(free);
  assign sel_ok = {1'b0, bus.in_sel} < N_CH_V;
  assign bus.in_ready = bcast ? &free : (sel_ok ? free_pad[bus.in_sel] : 1'b1);
  assign acc = bus.in_valid & bus.in_ready;
  assign load = !acc ? '0 : bcast ? '1 : sel_ok ? (N_CH'(1) << bus.in_sel) : '0;
  assign drop = acc & ~bcast & ~sel_ok;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    demux_chan_reg #(.DW(DW)) u_reg (
      .clk(clk),
      .rst_n(rst_n),
      .load(load[k]),
      .din(bus.in_data),
      .ready(bus.out_ready[k]),
      .valid(valid_a[k]),
      .dout(dout_a[k])
    );
  end
  always_comb begin
    bus.out_valid = '0;
    bus.out_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      bus.out_valid[k] = valid_a[k];
      bus.out_data[k*DW +: DW] = dout_a[k];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.err_sel  <= 1'b0;
      bus.drop_cnt <= '0;
    end else begin
      bus.err_sel <= drop;
      if (drop && bus.drop_cnt != '1) bus.drop_cnt <= bus.drop_cnt + 1'b1;
    end
  end
endmodule
